// File: rtl/tag_ctrl.sv
// tag_ctrl: sequencer/arbiter that owns every port of the cache tag array.
// Runs the post-reset invalidate sweep and on-demand flush sweeps, arbitrates
// refill writes against lookups, and returns a registered per-lookup result.

// Property checker for the lookup response. It is kept apart from the datapath.
module tag_ctrl_chk #(
  parameter int NUM_WAYS = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  input logic                hit_i,
  input logic [NUM_WAYS-1:0] hit_way_i
);

  // Two ways holding the same valid tag for one set is a corrupted array.
  a_hit_way_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(hit_way_i));

  // The hit flag must agree with the way vector.
  a_hit_consistent: assert property (@(posedge clk_i) disable iff (rst_i)
    hit_i == (|hit_way_i));

endmodule

module tag_ctrl #(
  parameter int NUM_WAYS            = 4,
  parameter int NUM_BANKS           = 4,
  parameter int SETS_PER_BANK_WIDTH = 8,
  parameter int TAG_WIDTH           = 20,
  localparam int BW                 = $clog2(NUM_BANKS),
  localparam int IW                 = SETS_PER_BANK_WIDTH + BW
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           lkp_valid_i,
  output logic                           lkp_ready_o,
  input  logic [IW-1:0]                  lkp_index_i,
  input  logic [TAG_WIDTH-1:0]           lkp_tag_i,
  output logic                           lkp_rsp_valid_o,
  output logic                           lkp_hit_o,
  output logic [NUM_WAYS-1:0]            lkp_hit_way_o,
  output logic [NUM_WAYS-1:0]            lkp_victim_o,
  input  logic                           rfl_valid_i,
  output logic                           rfl_ready_o,
  input  logic [IW-1:0]                  rfl_index_i,
  input  logic [NUM_WAYS-1:0]            rfl_way_i,
  input  logic [TAG_WIDTH-1:0]           rfl_tag_i,
  input  logic                           flush_valid_i,
  output logic                           flush_ready_o,
  output logic                           flush_done_o,
  output logic                           busy_o,
  output logic [SETS_PER_BANK_WIDTH-1:0] ta_bank_addr_o,
  output logic [BW-1:0]                  ta_bank_sel_o,
  output logic [NUM_WAYS-1:0]            ta_we_way_o,
  output logic [TAG_WIDTH-1:0]           ta_wtag_o,
  output logic                           ta_wvalid_o,
  input  logic [NUM_WAYS*TAG_WIDTH-1:0]  ta_rtag_i,
  input  logic [NUM_WAYS-1:0]            ta_rvalid_i
);

  localparam int WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [IW-1:0] LAST_SET = {IW{1'b1}};
  localparam logic [WW-1:0] LAST_RR  = WW'(NUM_WAYS - 1);

  logic [1:0]           r_state;
  logic [IW-1:0]        r_ctr;
  logic [WW-1:0]        r_rr;
  logic                 r_rsp_valid;
  logic                 r_hit;
  logic [NUM_WAYS-1:0]  r_hit_way;
  logic [NUM_WAYS-1:0]  r_victim;
  logic                 r_flush_done;

  logic                 w_idle;
  logic                 w_sweep;
  logic                 w_sweep_last;
  logic                 w_flush_acc;
  logic                 w_rfl_acc;
  logic                 w_lkp_acc;
  logic [IW-1:0]        w_idx;
  logic [NUM_WAYS-1:0]  w_we;
  logic [TAG_WIDTH-1:0] w_wtag;
  logic                 w_wvalid;
  logic [NUM_WAYS-1:0]  w_hit_way;
  logic [NUM_WAYS-1:0]  w_victim;
  logic                 w_found;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_sweep      = (r_state == ST_INIT) || (r_state == ST_FLUSH);
  assign w_sweep_last = w_sweep && (r_ctr == LAST_SET);

  // Fixed priority in IDLE: flush beats refill beats lookup.
  assign flush_ready_o = w_idle;
  assign rfl_ready_o   = w_idle & ~flush_valid_i;
  assign lkp_ready_o   = w_idle & ~flush_valid_i & ~rfl_valid_i;

  assign w_flush_acc = flush_valid_i & flush_ready_o;
  assign w_rfl_acc   = rfl_valid_i & rfl_ready_o;
  assign w_lkp_acc   = lkp_valid_i & lkp_ready_o;

  assign busy_o          = ~w_idle;
  assign flush_done_o    = r_flush_done;
  assign lkp_rsp_valid_o = r_rsp_valid;
  assign lkp_hit_o       = r_hit;
  assign lkp_hit_way_o   = r_hit_way;
  assign lkp_victim_o    = r_victim;

  assign ta_bank_sel_o  = w_idx[BW-1:0];
  assign ta_bank_addr_o = w_idx[IW-1:BW];
  assign ta_we_way_o    = w_we;
  assign ta_wtag_o      = w_wtag;
  assign ta_wvalid_o    = w_wvalid;

  // Tag-array port mux: sweep, then granted refill, then granted lookup, else parked.
  always_comb begin
    w_idx    = {IW{1'b0}};
    w_we     = {NUM_WAYS{1'b0}};
    w_wtag   = {TAG_WIDTH{1'b0}};
    w_wvalid = 1'b0;
    if (w_sweep) begin
      w_idx = r_ctr;
      w_we  = {NUM_WAYS{1'b1}};
    end else if (w_rfl_acc) begin
      w_idx    = rfl_index_i;
      w_we     = rfl_way_i;
      w_wtag   = rfl_tag_i;
      w_wvalid = 1'b1;
    end else if (w_lkp_acc) begin
      w_idx = lkp_index_i;
    end else begin
      w_idx = {IW{1'b0}};
    end
  end

  // Tag compare per way and victim choice: lowest invalid way, else round-robin.
  always_comb begin
    w_hit_way = {NUM_WAYS{1'b0}};
    w_victim  = {NUM_WAYS{1'b0}};
    w_found   = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      w_hit_way[w] = ta_rvalid_i[w] & (ta_rtag_i[w*TAG_WIDTH +: TAG_WIDTH] == lkp_tag_i);
      if (!ta_rvalid_i[w] && !w_found) begin
        w_victim[w] = 1'b1;
        w_found     = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
    if (!w_found) begin
      w_victim[r_rr] = 1'b1;
    end else begin
      w_victim = w_victim;
    end
  end

  // Sequencer state and sweep counter; a sweep lasts exactly one pass over all sets.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_INIT;
      r_ctr   <= {IW{1'b0}};
    end else begin
      case (r_state)
        ST_INIT, ST_FLUSH: begin
          if (r_ctr == LAST_SET) begin
            r_state <= ST_IDLE;
            r_ctr   <= {IW{1'b0}};
          end else begin
            r_ctr <= r_ctr + IW'(1);
          end
        end
        ST_IDLE: begin
          if (w_flush_acc) begin
            r_state <= ST_FLUSH;
            r_ctr   <= {IW{1'b0}};
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_ctr   <= {IW{1'b0}};
        end
      endcase
    end
  end

  // Done pulse only for flush sweeps; it lands on the first IDLE cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= w_sweep_last && (r_state == ST_FLUSH);
    end
  end

  // Round-robin replacement pointer, stepped by every accepted refill.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr <= {WW{1'b0}};
    end else if (w_rfl_acc) begin
      r_rr <= (r_rr == LAST_RR) ? {WW{1'b0}} : r_rr + WW'(1);
    end else begin
      r_rr <= r_rr;
    end
  end

  // Lookup response registers; all fields read zero when no response is presented.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_valid <= 1'b0;
      r_hit       <= 1'b0;
      r_hit_way   <= {NUM_WAYS{1'b0}};
      r_victim    <= {NUM_WAYS{1'b0}};
    end else if (w_lkp_acc) begin
      r_rsp_valid <= 1'b1;
      r_hit       <= |w_hit_way;
      r_hit_way   <= w_hit_way;
      r_victim    <= w_victim;
    end else begin
      r_rsp_valid <= 1'b0;
      r_hit       <= 1'b0;
      r_hit_way   <= {NUM_WAYS{1'b0}};
      r_victim    <= {NUM_WAYS{1'b0}};
    end
  end

  tag_ctrl_chk #(.NUM_WAYS(NUM_WAYS)) u_chk (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .hit_i     (r_hit),
    .hit_way_i (r_hit_way)
  );

endmodule

// File: tb/tb_tag_ctrl.sv
// tb_tag_ctrl: table-driven bench with a behavioural tag array and a response scoreboard.
module tb_tag_ctrl;

  localparam int NW = 4;
  localparam int TW = 20;
  localparam int BW = 2;
  localparam int IW = 10;
  localparam int NSETS = 1024;
  localparam int OP_RFL = 0;
  localparam int OP_LKP = 1;

  logic clk = 1'b0;
  logic rst_i;
  logic lkp_valid_i, lkp_ready_o, lkp_rsp_valid_o, lkp_hit_o;
  logic [IW-1:0] lkp_index_i, rfl_index_i;
  logic [TW-1:0] lkp_tag_i, rfl_tag_i, ta_wtag_o;
  logic [NW-1:0] lkp_hit_way_o, lkp_victim_o, rfl_way_i, ta_we_way_o, ta_rvalid_i;
  logic rfl_valid_i, rfl_ready_o, flush_valid_i, flush_ready_o, flush_done_o, busy_o;
  logic [7:0] ta_bank_addr_o;
  logic [BW-1:0] ta_bank_sel_o;
  logic ta_wvalid_o;
  logic [NW*TW-1:0] ta_rtag_i;

  always #5 clk = ~clk;

  tag_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .lkp_valid_i(lkp_valid_i), .lkp_ready_o(lkp_ready_o),
    .lkp_index_i(lkp_index_i), .lkp_tag_i(lkp_tag_i),
    .lkp_rsp_valid_o(lkp_rsp_valid_o), .lkp_hit_o(lkp_hit_o),
    .lkp_hit_way_o(lkp_hit_way_o), .lkp_victim_o(lkp_victim_o),
    .rfl_valid_i(rfl_valid_i), .rfl_ready_o(rfl_ready_o),
    .rfl_index_i(rfl_index_i), .rfl_way_i(rfl_way_i), .rfl_tag_i(rfl_tag_i),
    .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o),
    .flush_done_o(flush_done_o), .busy_o(busy_o),
    .ta_bank_addr_o(ta_bank_addr_o), .ta_bank_sel_o(ta_bank_sel_o),
    .ta_we_way_o(ta_we_way_o), .ta_wtag_o(ta_wtag_o), .ta_wvalid_o(ta_wvalid_o),
    .ta_rtag_i(ta_rtag_i), .ta_rvalid_i(ta_rvalid_i)
  );

  // Behavioural tag array: combinational read, write at the clock edge.
  logic [TW-1:0] mem_tag [NW][NSETS];
  logic          mem_v   [NW][NSETS];
  logic [IW-1:0] bus_idx;
  assign bus_idx = {ta_bank_addr_o, ta_bank_sel_o};

  always_comb begin
    for (int w = 0; w < NW; w++) begin
      ta_rtag_i[w*TW +: TW] = mem_tag[w][bus_idx];
      ta_rvalid_i[w]        = mem_v[w][bus_idx];
    end
  end

  always @(posedge clk) begin
    for (int w = 0; w < NW; w++) begin
      if (ta_we_way_o[w]) begin
        mem_tag[w][bus_idx] <= ta_wtag_o;
        mem_v[w][bus_idx]   <= ta_wvalid_o;
      end
    end
  end

  // Scoreboard and counters.
  typedef struct packed {
    logic          hit;
    logic [NW-1:0] way;
    logic [NW-1:0] vic;
  } rsp_t;

  typedef struct {
    int            op;
    logic [IW-1:0] idx;
    logic [NW-1:0] way;
    logic [TW-1:0] tag;
    logic          e_hit;
    logic [NW-1:0] e_way;
    logic [NW-1:0] e_vic;
  } vec_t;

  rsp_t sb_q[$];
  int n_checks = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(input int op, input logic [IW-1:0] idx, input logic [NW-1:0] way,
                              input logic [TW-1:0] tag, input logic e_hit,
                              input logic [NW-1:0] e_way, input logic [NW-1:0] e_vic);
    vec_t v;
    v.op = op; v.idx = idx; v.way = way; v.tag = tag;
    v.e_hit = e_hit; v.e_way = e_way; v.e_vic = e_vic;
    return v;
  endfunction

  // Response monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    rsp_t e;
    if (lkp_rsp_valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got hit=%0b way=%b victim=%b with no lookup pending",
                 lkp_hit_o, lkp_hit_way_o, lkp_victim_o);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_hit_way_victim", {23'd0, lkp_hit_o, lkp_hit_way_o, lkp_victim_o},
            {23'd0, e.hit, e.way, e.vic});
      end
    end
  end

  task automatic apply(input vec_t v);
    @(negedge clk);
    if (v.op == OP_RFL) begin
      rfl_valid_i = 1'b1; rfl_index_i = v.idx; rfl_way_i = v.way; rfl_tag_i = v.tag;
      #1;
      chk("rfl_ready", {31'd0, rfl_ready_o}, 32'd1);
      chk("rfl_bus", {1'b0, ta_wvalid_o, ta_we_way_o, ta_wtag_o, bus_idx},
          {1'b0, 1'b1, v.way, v.tag, v.idx});
    end else begin
      lkp_valid_i = 1'b1; lkp_index_i = v.idx; lkp_tag_i = v.tag;
      #1;
      chk("lkp_ready", {31'd0, lkp_ready_o}, 32'd1);
      chk("lkp_bus", {18'd0, ta_we_way_o, bus_idx}, {18'd0, 4'b0000, v.idx});
      if (lkp_ready_o) sb_q.push_back('{hit: v.e_hit, way: v.e_way, vic: v.e_vic});
    end
    @(posedge clk);
    #1;
    rfl_valid_i = 1'b0;
    lkp_valid_i = 1'b0;
  endtask

  // Follows a sweep from the current negedge until busy_o drops (bounded).
  task automatic sweep(output int n_busy, output int n_bad, output int n_done);
    n_busy = 0; n_bad = 0; n_done = 0;
    while (busy_o === 1'b1 && n_busy < 3000) begin
      if (bus_idx !== n_busy[IW-1:0] || ta_we_way_o !== 4'b1111 || ta_wvalid_o !== 1'b0 ||
          ta_wtag_o !== 20'h0 || lkp_ready_o !== 1'b0 || rfl_ready_o !== 1'b0 ||
          flush_ready_o !== 1'b0) n_bad++;
      if (flush_done_o === 1'b1) n_done++;
      n_busy++;
      @(negedge clk);
    end
  endtask

  vec_t tbl[17];
  vec_t tail[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nbad, nd, cnt, k;
    tbl[0]  = mk(OP_RFL, 10'h3FF, 4'b0001, 20'h11111, 1'b0, 4'b0000, 4'b0000);
    tbl[1]  = mk(OP_RFL, 10'h3FF, 4'b0010, 20'h22222, 1'b0, 4'b0000, 4'b0000);
    tbl[2]  = mk(OP_RFL, 10'h3FF, 4'b0100, 20'h33333, 1'b0, 4'b0000, 4'b0000);
    tbl[3]  = mk(OP_RFL, 10'h3FF, 4'b1000, 20'h44444, 1'b0, 4'b0000, 4'b0000);
    tbl[4]  = mk(OP_LKP, 10'h3FF, 4'b0000, 20'h55555, 1'b0, 4'b0000, 4'b0001);
    tbl[5]  = mk(OP_LKP, 10'h3FF, 4'b0000, 20'h33333, 1'b1, 4'b0100, 4'b0001);
    tbl[6]  = mk(OP_RFL, 10'h005, 4'b0100, 20'hABCDE, 1'b0, 4'b0000, 4'b0000);
    tbl[7]  = mk(OP_LKP, 10'h005, 4'b0000, 20'hABCDE, 1'b1, 4'b0100, 4'b0001);
    tbl[8]  = mk(OP_LKP, 10'h005, 4'b0000, 20'h12345, 1'b0, 4'b0000, 4'b0001);
    tbl[9]  = mk(OP_LKP, 10'h105, 4'b0000, 20'hABCDE, 1'b0, 4'b0000, 4'b0001);
    tbl[10] = mk(OP_LKP, 10'h006, 4'b0000, 20'hABCDE, 1'b0, 4'b0000, 4'b0001);
    tbl[11] = mk(OP_RFL, 10'h3FF, 4'b0010, 20'h66666, 1'b0, 4'b0000, 4'b0000);
    tbl[12] = mk(OP_LKP, 10'h3FF, 4'b0000, 20'h66666, 1'b1, 4'b0010, 4'b0100);
    tbl[13] = mk(OP_LKP, 10'h3FF, 4'b0000, 20'h22222, 1'b0, 4'b0000, 4'b0100);
    tbl[14] = mk(OP_RFL, 10'h005, 4'b0001, 20'h13579, 1'b0, 4'b0000, 4'b0000);
    tbl[15] = mk(OP_LKP, 10'h005, 4'b0000, 20'h13579, 1'b1, 4'b0001, 4'b0010);
    tbl[16] = mk(OP_LKP, 10'h3FF, 4'b0000, 20'h44444, 1'b1, 4'b1000, 4'b1000);
    tail[0] = mk(OP_LKP, 10'h005, 4'b0000, 20'hABCDE, 1'b0, 4'b0000, 4'b0001);
    tail[1] = mk(OP_LKP, 10'h3FF, 4'b0000, 20'h33333, 1'b0, 4'b0000, 4'b0001);
    tail[2] = mk(OP_RFL, 10'h123, 4'b1000, 20'h0F0F0, 1'b0, 4'b0000, 4'b0000);
    tail[3] = mk(OP_LKP, 10'h123, 4'b0000, 20'h0F0F0, 1'b1, 4'b1000, 4'b0001);

    for (int w = 0; w < NW; w++) begin
      for (int s = 0; s < NSETS; s++) begin
        mem_tag[w][s] <= 20'($urandom);
        mem_v[w][s]   <= 1'b1;
      end
    end
    rst_i = 1'b1;
    lkp_valid_i = 1'b0; lkp_index_i = '0; lkp_tag_i = '0;
    rfl_valid_i = 1'b0; rfl_index_i = '0; rfl_way_i = '0; rfl_tag_i = '0;
    flush_valid_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy_o}, 32'd1);
    chk("reset_outs", {26'd0, lkp_rsp_valid_o, flush_done_o, lkp_ready_o, rfl_ready_o,
                       flush_ready_o, lkp_hit_o}, 32'd0);
    chk("reset_bus", {18'd0, ta_we_way_o, bus_idx}, {18'd0, 4'b1111, 10'h000});

    // Post-reset invalidate sweep.
    rst_i = 1'b0;
    sweep(nb, nbad, nd);
    chk("init_busy_cycles", nb, 32'd1024);
    chk("init_sweep_bus", nbad, 32'd0);
    chk("init_no_done", nd + {31'd0, flush_done_o}, 32'd0);
    cnt = 0;
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < NSETS; s++)
        if (mem_v[w][s] !== 1'b0) cnt++;
    chk("init_all_invalid", cnt, 32'd0);
    chk("idle_readies", {29'd0, flush_ready_o, rfl_ready_o, lkp_ready_o}, 32'd7);
    chk("idle_bus", {18'd0, ta_we_way_o, bus_idx}, 32'd0);

    for (int i = 0; i < 17; i++) apply(tbl[i]);

    // Lookup followed by simultaneous flush/refill/lookup: only flush granted.
    @(negedge clk);
    lkp_valid_i = 1'b1; lkp_index_i = 10'h005; lkp_tag_i = 20'h13579;
    #1;
    if (lkp_ready_o) sb_q.push_back('{hit: 1'b1, way: 4'b0001, vic: 4'b0010});
    @(posedge clk);
    #1;
    lkp_valid_i = 1'b0;
    @(negedge clk);
    flush_valid_i = 1'b1;
    rfl_valid_i = 1'b1; rfl_index_i = 10'h005; rfl_way_i = 4'b0010; rfl_tag_i = 20'h77777;
    lkp_valid_i = 1'b1; lkp_index_i = 10'h3FF; lkp_tag_i = 20'h33333;
    #1;
    chk("collide_readies", {29'd0, flush_ready_o, rfl_ready_o, lkp_ready_o}, 32'd4);
    chk("collide_no_write", {28'd0, ta_we_way_o}, 32'd0);
    @(posedge clk);
    #1;
    flush_valid_i = 1'b0; rfl_valid_i = 1'b0; lkp_valid_i = 1'b0;
    @(negedge clk);
    sweep(nb, nbad, nd);
    chk("flush_busy_cycles", nb, 32'd1024);
    chk("flush_sweep_bus", nbad, 32'd0);
    chk("flush_done_not_early", nd, 32'd0);
    chk("flush_done_pulse", {31'd0, flush_done_o}, 32'd1);
    @(negedge clk);
    chk("flush_done_one_cycle", {31'd0, flush_done_o}, 32'd0);
    apply(tail[0]);
    apply(tail[1]);
    apply(mk(OP_LKP, 10'h005, 4'b0000, 20'h77777, 1'b0, 4'b0000, 4'b0001));

    // Reset in the middle of a flush sweep.
    @(negedge clk);
    flush_valid_i = 1'b1;
    @(posedge clk);
    #1;
    flush_valid_i = 1'b0;
    @(negedge clk);
    k = 0;
    while (bus_idx !== 10'd300 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("midflush_reached_300", {22'd0, bus_idx}, 32'd300);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("midflush_restart", {21'd0, busy_o, bus_idx}, {21'd0, 1'b1, 10'h000});
    sweep(nb, nbad, nd);
    chk("reinit_busy_cycles", nb, 32'd1024);
    chk("reinit_sweep_bus", nbad, 32'd0);
    cnt = nd;
    repeat (3) begin
      if (flush_done_o !== 1'b0) cnt++;
      @(negedge clk);
    end
    chk("reinit_no_done", cnt, 32'd0);
    apply(tail[2]);
    apply(tail[3]);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
